// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   ls_width_e  : access width code from the decoder
//   lsu_state_e : load/store FSM states
//   norm_width  : maps a raw 3-bit width code to a width (unknown codes -> word)
//   is_misaligned : true when the access does not sit on its natural boundary
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    LS_BYTE = 3'b000,
    LS_HALF = 3'b001,
    LS_WORD = 3'b010
  } ls_width_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } lsu_state_e;

  function automatic ls_width_e norm_width(input logic [2:0] code);
    case (code)
      3'b000:  return LS_BYTE;
      3'b001:  return LS_HALF;
      default: return LS_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input ls_width_e width, input logic [1:0] off);
    case (width)
      LS_BYTE: return 1'b0;
      LS_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane mapper.
//   Store side: st_width/st_off/st_data -> be (byte enables), st_wdata (lane-replicated)
//   Load side : ld_width/ld_unsigned/ld_off/rdata -> ld_data (shifted and extended)
module lsu_align
  import lsu_pkg::*;
(
  input  ls_width_e         st_width,
  input  logic [1:0]        st_off,
  input  logic [XLEN-1:0]   st_data,
  output logic [3:0]        be,
  output logic [XLEN-1:0]   st_wdata,
  input  ls_width_e         ld_width,
  input  logic              ld_unsigned,
  input  logic [1:0]        ld_off,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   ld_data
);

  logic [XLEN-1:0] shifted;

  // Store lanes: narrow data is replicated so every enabled lane carries it
  always_comb begin
    be       = 4'b1111;
    st_wdata = st_data;
    case (st_width)
      LS_BYTE: begin
        be       = 4'(4'b0001 << st_off);
        st_wdata = {4{st_data[7:0]}};
      end
      LS_HALF: begin
        be       = 4'(4'b0011 << st_off);
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend
  always_comb begin
    shifted = rdata >> {ld_off, 3'b000};
    ld_data = shifted;
    case (ld_width)
      LS_BYTE: ld_data = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
      LS_HALF: ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: single-outstanding data-memory bus master.
//   Upstream : in_valid, is_load, mem_write, load_type, store_type, load_unsigned,
//              addr, wdata, rd; stall back to the pipeline (combinational).
//   Bus      : mem_req_valid/mem_req_ready, mem_we, mem_addr, mem_be, mem_wdata,
//              mem_rsp_valid, mem_rdata.
//   Results  : wb_valid, wb_data, wb_rd, misalign_err, bus_err (one-cycle strobes).
//   TIMEOUT  : max RESP cycles before bus_err; 0 disables the timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              is_load,
  input  logic              mem_write,
  input  logic [2:0]        load_type,
  input  logic [2:0]        store_type,
  input  logic              load_unsigned,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [4:0]        rd,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_data,
  output logic [4:0]        wb_rd,
  output logic              misalign_err,
  output logic              bus_err
);

  // A zero TIMEOUT still needs a legal counter width
  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_e       state;
  logic             mem_op;
  ls_width_e        cur_width;
  logic             op_load;
  ls_width_e        op_width;
  logic             op_unsigned;
  logic [1:0]       op_off;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       st_be;
  logic [XLEN-1:0]  st_wdata;
  logic [XLEN-1:0]  ld_data;

  // Load wins when both decoder controls are set
  always_comb begin
    mem_op    = in_valid & (is_load | mem_write);
    cur_width = norm_width(is_load ? load_type : store_type);
  end

  // Stall covers the accepting cycle and every cycle the bus is busy
  always_comb begin
    stall = ((state == ST_IDLE) && mem_op) || (state == ST_REQ) || (state == ST_RESP);
  end

  lsu_align u_align (
    .st_width    (cur_width),
    .st_off      (addr[1:0]),
    .st_data     (wdata),
    .be          (st_be),
    .st_wdata    (st_wdata),
    .ld_width    (op_width),
    .ld_unsigned (op_unsigned),
    .ld_off      (op_off),
    .rdata       (mem_rdata),
    .ld_data     (ld_data)
  );

  // FSM, capture registers and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      op_load       <= 1'b0;
      op_width      <= LS_BYTE;
      op_unsigned   <= 1'b0;
      op_off        <= 2'b00;
      cnt           <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= '0;
      mem_wdata     <= '0;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_rd         <= '0;
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_op) begin
            op_load     <= is_load;
            op_width    <= cur_width;
            op_unsigned <= load_unsigned;
            op_off      <= addr[1:0];
            wb_rd       <= rd;
            if (is_misaligned(cur_width, addr[1:0])) begin
              misalign_err <= 1'b1;
              state        <= ST_DONE;
            end else begin
              mem_req_valid <= 1'b1;
              mem_we        <= ~is_load;
              mem_addr      <= {addr[XLEN-1:2], 2'b00};
              mem_be        <= st_be;
              mem_wdata     <= st_wdata;
              state         <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (op_load) begin
              cnt   <= '0;
              state <= ST_RESP;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_RESP: begin
          // A response in the final allowed cycle still beats the timeout
          if (mem_rsp_valid) begin
            wb_data  <= ld_data;
            wb_valid <= 1'b1;
            state    <= ST_DONE;
          end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
            bus_err <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
